fnd_scan_driver: RTL and testbench
==================================

# fnd_scan_driver

Parametrised, time-multiplexed seven-segment (FND) display driver for the SOC readout. It accepts an unsigned binary value through a valid/ready handshake and converts it to BCD sequentially (shift-and-add-3, one bit per cycle). It then scans the digits onto a shared active-low segment bus with per-digit active-low anode enables. It replaces the fixed two-digit combinational decoder on boards with multi-digit common-anode displays.

## Interface
- DIGITS, 4: number of display digits (1..8).
- DATA_W, 14: width of input value; must satisfy 2^DATA_W ≥ 10^DIGITS is not required (overflow handled).
- SCAN_DIV, 50000: clk cycles each digit is shown, including blank cycle (≥2).

- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- value  in  DATA_W  unsigned binary value to display.
- value_valid  in  1  request to load value.
- ready  out  1  high when idle; load accepted on clk edge with value_valid & ready.
- overflow  out  1  displayed value exceeded 10^DIGITS−1.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  out  DIGITS  digit enables, active-low, at most one low.

## Operation
- FSM states: IDLE, CONV.
  - IDLE: ready=1. On accept, latch value into shift register, clear BCD register, latch overflow flag (value > 10^DIGITS−1), bit counter=DATA_W−1, go CONV.
  - CONV: ready=0. Each cycle: every BCD nibble ≥5 gets +3, then shift {bcd,shift} left by one. After the DATA_W-th shift, copy BCD nibbles and overflow flag into display register atomically, go IDLE.
  - value_valid while in CONV is ignored, not queued.
- BCD register width 4·DIGITS; bits shifted out of the top are discarded; overflow flag governs display.
- Scan: divider counts 0..SCAN_DIV−1; at wrap, digit index advances 0→1→…→DIGITS−1→0. Digit 0 is least significant, an_n[0].
  - Divider count 0 of each digit is a blank cycle: an_n all ones (anti-ghosting). Counts 1..SCAN_DIV−1: an_n[idx]=0.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111, dash=0111111.
- Overflow set in display register: every digit shows dash.
- Scanning runs continuously and is unaffected by conversions; display register changes only at end of CONV.

## Timing
- Reset values: seg_n=7'h7F, an_n all ones, ready=1, overflow=0, FSM IDLE, divider 0, index 0, display register 0.
- seg_n and an_n are registered; both change on the same edge, so no digit shows the previous digit's pattern.
- Latency: accept on edge 0; display register updated on edge DATA_W; new pattern on seg_n on edge DATA_W+1 if digit is being driven; ready high again after edge DATA_W.
- Back-to-back: a load may be accepted on the first cycle ready is high.
- Reset mid-conversion: conversion aborted, display returns to 0, ready=1 immediately.
- Divider wrap and conversion end on the same edge: both take effect; new digit shows new data.

## Configuration
- FND_LZB_EN defined: leading-zero blanking. Digits above the most significant non-zero digit show blank; digit 0 always shows its value ("0" for zero). Not applied when overflow is set.
- FND_LZB_EN undefined: all DIGITS digits show their BCD value, including leading zeros.

## Test plan
- Reset, DIGITS=4, DATA_W=14, SCAN_DIV=4 -> seg_n=7F, an_n=F, ready=1, overflow=0 during and one cycle after reset.
- Load 1234 -> ready low 14 cycles. Then the scan shows an_n=1110/seg 0011001, 1101/0110000, 1011/0100100, 0111/1111001, with an_n=F on each blank cycle.
- Load 7: with FND_LZB_EN, digits 1–3 show 1111111 and digit 0 shows 1111000. Without the macro, digits 1–3 show 1000000.
- Load 0 with FND_LZB_EN -> digit 0 shows 1000000, others blank. Then load 10000 -> overflow=1, all digits 0111111.
- Load 9999, then pulse value_valid with 1 during CONV -> second request ignored; display shows 9999.
- Load 5678, assert n_rst low at cycle 5 of CONV -> outputs return to reset values immediately. After release, display shows "0" (digit 0 = 1000000).

Source files
------------

// File: rtl/fnd_scan_driver_if.sv
// Load handshake between a value producer and the FND scan driver.
// The producer offers a binary value; the driver takes it when ready is high.
interface fnd_scan_driver_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] value;
    logic              value_valid;
    logic              ready;

    modport master (
        output value,
        output value_valid,
        input  ready
    );

    modport slave (
        input  value,
        input  value_valid,
        output ready
    );
endinterface

// File: rtl/fnd_scan_driver.sv
// Multi-digit common-anode FND driver: sequential binary-to-BCD conversion plus digit scanning.
// Define FND_LZB_EN to blank leading zeros above the most significant non-zero digit.
//
//   state | meaning
//   IDLE  | ready high, waiting for a value to load
//   CONV  | shift-and-add-3, one input bit per cycle, display register updated on last bit
module fnd_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               n_rst,
    fnd_scan_driver_if.slave   bus,
    output logic               overflow,
    output logic [6:0]         seg_n,
    output logic [DIGITS-1:0]  an_n
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               disp_ovf_q, disp_ovf_d;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [DIGITS-1:0]  an_q, an_d;

    logic [63:0]        value_ext;
    logic [3:0]         nib;
    logic               lz_blank;

    assign value_ext = 64'(bus.value);
    assign bus.ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            disp_q     <= disp_d;
            disp_ovf_q <= disp_ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        disp_d     = disp_q;
        disp_ovf_d = disp_ovf_q;
        bcd_adj    = bcd_q;

        case (state_q)
            IDLE: begin
                if (bus.value_valid) begin
                    shift_d    = bus.value;
                    bcd_d      = '0;
                    ovf_pend_d = (value_ext > LIMIT);
                    cnt_d      = CNT_W'(DATA_W - 1);
                    state_d    = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) begin
                        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                    end
                end
                // Top BCD bit is dropped on the shift; the overflow flag covers that case.
                bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
                    disp_d     = bcd_d;
                    disp_ovf_d = ovf_pend_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib = disp_q[4*i +: 4];
            end
        end
    end

`ifdef FND_LZB_EN
    logic zero_above;

    always_comb begin
        zero_above = 1'b1;
        lz_blank   = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'd0);
            if ((idx_q == IDX_W'(i)) && zero_above) begin
                lz_blank = 1'b1;
            end
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Both outputs are computed from the same pre-edge state, so segments and anodes switch together.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        if (div_q != '0) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (disp_ovf_q) begin
                seg_d = SEG_DASH;
            end else if (lz_blank) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = seg_decode(nib);
            end
        end
    end

    assign seg_n    = seg_q;
    assign an_n     = an_q;
    assign overflow = disp_ovf_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with DIGITS=4, DATA_W=14, SCAN_DIV=4.
// Expected leading-digit patterns follow FND_LZB_EN when it is defined for the build.
module tb_fnd_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000,
                           S9 = 7'b0010000, SB = 7'b1111111, SD = 7'b0111111;
`ifdef FND_LZB_EN
    localparam logic [6:0] ZPAD = SB;
`else
    localparam logic [6:0] ZPAD = S0;
`endif

    logic       clk;
    logic       n_rst;
    logic       overflow;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    int         n_checks;
    int         n_fail;
    int         busy;

    fnd_scan_driver_if #(.DATA_W(14)) bus ();

    fnd_scan_driver #(.DIGITS(4), .DATA_W(14), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .bus      (bus.slave),
        .overflow (overflow),
        .seg_n    (seg_n),
        .an_n     (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_digit(input int d, input logic [6:0] exp, input string tag);
        logic [3:0] want;
        bit         found;
        want  = ~(4'b0001 << d);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an_n === want) found = 1'b1;
        end
        if (found) chk(tag, {25'd0, seg_n}, {25'd0, exp});
        else       chk({tag, "_an_timeout"}, {28'd0, an_n}, {28'd0, want});
    endtask

    task automatic check_blank(input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (an_n === 4'hF) found = 1'b1;
        end
        if (found) chk(tag, {25'd0, seg_n}, {25'd0, SB});
        else       chk({tag, "_timeout"}, {28'd0, an_n}, 32'hF);
    endtask

    task automatic load(input logic [13:0] v, output int cycles);
        @(negedge clk);
        bus.value       = v;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        cycles = 0;
        while (bus.ready === 1'b0 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        n_rst           = 1'b0;
        bus.value       = '0;
        bus.value_valid = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_seg",   {25'd0, seg_n}, 32'h7F);
        chk("rst_an",    {28'd0, an_n},  32'hF);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_ovf",   {31'd0, overflow},  32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_seg",   {25'd0, seg_n}, 32'h7F);
        chk("post_rst_an",    {28'd0, an_n},  32'hF);
        chk("post_rst_ready", {31'd0, bus.ready}, 32'd1);

        // 1234
        load(14'd1234, busy);
        chk("busy_1234", busy, 32'd14);
        chk("ovf_1234", {31'd0, overflow}, 32'd0);
        check_digit(0, S4, "d0_1234");
        check_digit(1, S3, "d1_1234");
        check_digit(2, S2, "d2_1234");
        check_digit(3, S1, "d3_1234");
        check_blank("blank_1234");

        // 7
        load(14'd7, busy);
        chk("busy_7", busy, 32'd14);
        check_digit(0, S7,   "d0_7");
        check_digit(1, ZPAD, "d1_7");
        check_digit(2, ZPAD, "d2_7");
        check_digit(3, ZPAD, "d3_7");

        // 0 then overflow
        load(14'd0, busy);
        check_digit(0, S0,   "d0_0");
        check_digit(3, ZPAD, "d3_0");
        load(14'd10000, busy);
        chk("ovf_10000", {31'd0, overflow}, 32'd1);
        check_digit(0, SD, "d0_10000");
        check_digit(3, SD, "d3_10000");

        // 9999 with an ignored request during conversion
        @(negedge clk);
        bus.value       = 14'd9999;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.value       = 14'd1;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        busy = 0;
        while (bus.ready === 1'b0 && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        chk("busy_9999", busy, 32'd10);
        chk("ovf_9999", {31'd0, overflow}, 32'd0);
        check_digit(0, S9, "d0_9999");
        check_digit(1, S9, "d1_9999");
        check_digit(3, S9, "d3_9999");
        repeat (20) @(negedge clk);
        chk("ready_after_9999", {31'd0, bus.ready}, 32'd1);
        check_digit(2, S9, "d2_9999_late");

        // 5678 aborted by reset
        @(negedge clk);
        bus.value       = 14'd5678;
        bus.value_valid = 1'b1;
        @(negedge clk);
        bus.value_valid = 1'b0;
        chk("busy_5678", {31'd0, bus.ready}, 32'd0);
        repeat (4) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("abort_seg",   {25'd0, seg_n}, 32'h7F);
        chk("abort_an",    {28'd0, an_n},  32'hF);
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_ovf",   {31'd0, overflow},  32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        check_digit(0, S0,   "d0_abort");
        check_digit(1, ZPAD, "d1_abort");
        check_digit(2, ZPAD, "d2_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
